// File: rtl/issue_hazard_scoreboard_pkg.sv
// Shared register-file geometry and hazard helpers for the dual-issue ID-stage scoreboard.
package issue_hazard_scoreboard_pkg;

  localparam int unsigned NUM_REGISTERS      = 32;
  localparam int unsigned NUM_REGISTERS_LOG2 = 5;
  localparam int unsigned LAT_BITS           = 3;

  typedef logic [NUM_REGISTERS_LOG2-1:0] reg_idx_t;

  // r0 is hard-wired, so it can never carry a pending result.
  function automatic logic reg_busy(input reg_idx_t r, input logic [NUM_REGISTERS-1:0] busy);
    return (r != '0) && busy[r];
  endfunction

endpackage

// File: rtl/issue_hazard_scoreboard_if.sv
// ID-stage issue bundle: decoded lane operands in, issue/stall decisions and scoreboard status out.
interface issue_hazard_scoreboard_if
  import issue_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W       = LAT_BITS,
  parameter int unsigned STALL_CNT_W = 32
);

  logic                     freeze;
  logic                     id_valid0;
  logic                     id_valid1;
  reg_idx_t                 id_rs0;
  reg_idx_t                 id_rs1;
  reg_idx_t                 id_rt0;
  reg_idx_t                 id_rt1;
  reg_idx_t                 id_rd0;
  reg_idx_t                 id_rd1;
  logic                     id_reg_write0;
  logic                     id_reg_write1;
  logic [LAT_W-1:0]         id_lat0;
  logic [LAT_W-1:0]         id_lat1;
  logic                     issue0;
  logic                     issue1;
  logic                     stall;
  logic                     split;
  logic [NUM_REGISTERS-1:0] busy_mask;
  logic [STALL_CNT_W-1:0]   stall_count;

  modport master (
    output freeze, id_valid0, id_valid1, id_rs0, id_rs1, id_rt0, id_rt1,
           id_rd0, id_rd1, id_reg_write0, id_reg_write1, id_lat0, id_lat1,
    input  issue0, issue1, stall, split, busy_mask, stall_count
  );

  modport slave (
    input  freeze, id_valid0, id_valid1, id_rs0, id_rs1, id_rt0, id_rt1,
           id_rd0, id_rd1, id_reg_write0, id_reg_write1, id_lat0, id_lat1,
    output issue0, issue1, stall, split, busy_mask, stall_count
  );

endinterface

// File: rtl/issue_hazard_scoreboard_entry.sv
// One register's in-flight latency countdown: load on issue, hold on freeze, count down to idle.
module issue_hazard_scoreboard_entry #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy
);

  logic [LAT_W-1:0] cnt;

  // A fresh load wins over the decrement of the previous producer.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end

  always_comb busy = (cnt != '0);

endmodule

// File: rtl/issue_hazard_scoreboard.sv
// Dual-issue ID-stage issue controller: stalls consumers of multi-cycle results until forwardable,
// drives PC/IF-ID hold and lane split, and counts stall cycles.
module issue_hazard_scoreboard
  import issue_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W       = LAT_BITS,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  issue_hazard_scoreboard_if.slave  sb
);

  logic [NUM_REGISTERS-1:0] busy;
  logic [LAT_W-1:0]         lat0;
  logic [LAT_W-1:0]         lat1;
  logic                     haz0;
  logic                     haz1;
  logic                     intra;
  logic                     go;
  logic                     issue0;
  logic                     issue1;
  logic                     stall;
  logic                     wr0;
  logic                     wr1;
  logic [STALL_CNT_W-1:0]   stall_count;

  always_comb begin
    lat0 = sb.id_lat0;
    lat1 = sb.id_lat1;

    haz0 = reg_busy(sb.id_rs0, busy) | reg_busy(sb.id_rt0, busy)
         | (sb.id_reg_write0 & reg_busy(sb.id_rd0, busy));
    haz1 = reg_busy(sb.id_rs1, busy) | reg_busy(sb.id_rt1, busy)
         | (sb.id_reg_write1 & reg_busy(sb.id_rd1, busy));

    // Lane1 reading or re-writing lane0's destination must wait for the next slot.
    intra = sb.id_reg_write0 && (sb.id_rd0 != '0)
         && ((sb.id_rs1 == sb.id_rd0) || (sb.id_rt1 == sb.id_rd0)
             || (sb.id_reg_write1 && (sb.id_rd1 == sb.id_rd0)));

    go     = !reset && !sb.freeze;
    issue0 = go && sb.id_valid0 && !haz0;
    issue1 = issue0 && sb.id_valid1 && !haz1 && !intra;
    stall  = go && ((sb.id_valid0 && !issue0) || (sb.id_valid1 && !issue1));

    wr0 = issue0 && sb.id_reg_write0 && (sb.id_rd0 != '0) && (lat0 != '0);
    wr1 = issue1 && sb.id_reg_write1 && (sb.id_rd1 != '0) && (lat1 != '0);
  end

  always_comb begin
    sb.issue0      = issue0;
    sb.issue1      = issue1;
    sb.stall       = stall;
    sb.split       = issue0 && sb.id_valid1 && !issue1;
    sb.busy_mask   = busy;
    sb.stall_count = stall_count;
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_entry
    logic             hit0;
    logic             hit1;
    logic             load;
    logic [LAT_W-1:0] load_val;

    always_comb begin
      hit0     = wr0 && (sb.id_rd0 == reg_idx_t'(r));
      hit1     = wr1 && (sb.id_rd1 == reg_idx_t'(r));
      load     = hit0 || hit1;
      load_val = hit0 ? lat0 : lat1;
    end

    issue_hazard_scoreboard_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .freeze   (sb.freeze),
      .load     (load),
      .load_val (load_val),
      .busy     (busy[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!sb.freeze && stall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule
